// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - glyph constants, conversion states and glyph decode
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// rtl/seg_scan_driver_bin2bcd.sv - one sequential shift-add-3 binary to BCD datapath
module bin2bcd_seq #(
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [VAL_W-1:0] bin,
  output logic [15:0]      bcd
);

  logic [VAL_W-1:0] bin_sr;
  logic [15:0]      bcd_sr;
  logic [15:0]      adj;

  // Correct every nibble that would overflow past 9 once doubled.
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (load) begin
      bin_sr <= bin;
      bcd_sr <= '0;
    end else if (shift_en) begin
      bcd_sr <= {adj[14:0], bin_sr[VAL_W-1]};
      bin_sr <= bin_sr << 1;
    end
  end

  assign bcd = bcd_sr;

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - dual BCD conversion and 8-digit multiplexed seven-segment scan
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV      = 10000,
  parameter int VAL_W         = 7,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] val_hi,
  input  logic [VAL_W-1:0] val_lo,
  output logic [7:0]       DIGIT,
  output logic [6:0]       SEG,
  output logic             conv_done
);

  localparam int                ITER_W    = $clog2(VAL_W + 1);
  localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_INIT = ITER_W'(VAL_W);

  conv_state_t       state;
  logic [ITER_W-1:0] iter;
  logic [15:0]       bcd_hi;
  logic [15:0]       bcd_lo;
  logic [15:0]       shown_hi;
  logic [15:0]       shown_lo;
  logic              load;
  logic              shift_en;

  assign load     = (state == LOAD);
  assign shift_en = (state == SHIFT);

  bin2bcd_seq #(.VAL_W(VAL_W)) u_conv_hi (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .bin      (val_hi),
    .bcd      (bcd_hi)
  );

  bin2bcd_seq #(.VAL_W(VAL_W)) u_conv_lo (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .bin      (val_lo),
    .bcd      (bcd_lo)
  );

  // Both groups are committed on the same edge so the display never mixes old and new.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      iter      <= '0;
      shown_hi  <= '0;
      shown_lo  <= '0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= LOAD;
        end
        LOAD: begin
          iter  <= ITER_INIT;
          state <= SHIFT;
        end
        SHIFT: begin
          iter <= iter - ITER_W'(1);
          if (iter == ITER_W'(1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          shown_hi  <= bcd_hi;
          shown_lo  <= bcd_lo;
          conv_done <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
      DIGIT    <= 8'b1111_1110;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
      DIGIT    <= {DIGIT[6:0], DIGIT[7]};
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  logic [15:0] group;
  logic [1:0]  pos;
  logic [3:0]  nib;
  logic        blank;

  // A digit is blank when it and every higher digit of its group are zero; ones never blank.
  always_comb begin
    group = idx[2] ? shown_hi : shown_lo;
    pos   = idx[1:0];
    nib   = group[{pos, 2'b00} +: 4];
    blank = 1'b0;
    if ((BLANK_LEADING != 0) && (pos != 2'd0)) begin
      blank = ((group >> {pos, 2'b00}) == 16'd0);
    end
    SEG = blank ? SEG_BLANK : seg_glyph(nib);
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int VW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] val_hi = '0;
  logic [VW-1:0] val_lo = '0;
  logic [7:0]    digit_a, digit_b, digit_c;
  logic [6:0]    seg_a, seg_b, seg_c;
  logic          done_a, done_b, done_c;
  int            n_vec = 0;
  int            n_miss = 0;
  int            cyc = 0;
  logic [6:0]    exp_a [8];
  logic [6:0]    exp_b [8];
  logic [6:0]    exp_c [8];

  always #5 clk = ~clk;

  // Non-reset edges since the last reset; the scan position follows from it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  seg_scan_driver #(.SCAN_DIV(4), .VAL_W(VW), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .rst(rst), .val_hi(val_hi), .val_lo(val_lo),
    .DIGIT(digit_a), .SEG(seg_a), .conv_done(done_a)
  );

  seg_scan_driver #(.SCAN_DIV(1), .VAL_W(VW), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .rst(rst), .val_hi(val_hi), .val_lo(val_lo),
    .DIGIT(digit_b), .SEG(seg_b), .conv_done(done_b)
  );

  seg_scan_driver #(.SCAN_DIV(1), .VAL_W(VW), .BLANK_LEADING(0)) dut_c (
    .clk(clk), .rst(rst), .val_hi(val_hi), .val_lo(val_lo),
    .DIGIT(digit_c), .SEG(seg_c), .conv_done(done_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_a) break;
    end
    check({tag, "_done_a"}, done_a, 1);
    check({tag, "_done_b"}, done_b, 1);
    check({tag, "_done_c"}, done_c, 1);
  endtask

  task automatic reset_seq(input string tag);
    int first;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_digit"}, digit_a, 8'b1111_1110);
    check({tag, "_seg"}, seg_a, 7'h3F);
    check({tag, "_done"}, done_a, 0);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a) begin
        first = k;
        break;
      end
      check({tag, "_zero_shown"}, seg_c, 7'h3F);
    end
    check({tag, "_latency"}, first, 10);
  endtask

  task automatic scan_a(input string tag, input int n);
    int         i;
    logic [7:0] d;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      i = (cyc / 4) % 8;
      d = ~(8'b1 << i);
      check({tag, "_digit"}, digit_a, d);
      check({tag, "_seg"}, seg_a, exp_a[i]);
    end
  endtask

  task automatic scan_bc(input string tag, input int n);
    int         i;
    logic [7:0] d;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      i = cyc % 8;
      d = ~(8'b1 << i);
      check({tag, "_digit_b"}, digit_b, d);
      check({tag, "_seg_b"}, seg_b, exp_b[i]);
      check({tag, "_seg_c"}, seg_c, exp_c[i]);
    end
  endtask

  initial begin
    val_hi = 7'd23;
    val_lo = 7'd8;
    reset_seq("rst1");

    exp_a = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h4F, 7'h5B, 7'h00, 7'h00};
    scan_a("basic", 32);

    val_hi = 7'd127;
    val_lo = 7'd0;
    wait_done("max_w1");
    wait_done("max_w2");
    exp_b = '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h07, 7'h5B, 7'h06, 7'h00};
    exp_c = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h07, 7'h5B, 7'h06, 7'h3F};
    scan_bc("max_zero_wrap", 9);

    val_lo = 7'd7;
    wait_done("mid_w1");
    wait_done("mid_w2");
    repeat (3) @(negedge clk);
    val_lo = 7'd99;
    wait_done("mid_w3");
    exp_b = '{7'h07, 7'h00, 7'h00, 7'h00, 7'h07, 7'h5B, 7'h06, 7'h00};
    exp_c = '{7'h07, 7'h3F, 7'h3F, 7'h3F, 7'h07, 7'h5B, 7'h06, 7'h3F};
    scan_bc("mid_old", 8);
    wait_done("mid_w4");
    exp_b = '{7'h6F, 7'h6F, 7'h00, 7'h00, 7'h07, 7'h5B, 7'h06, 7'h00};
    exp_c = '{7'h6F, 7'h6F, 7'h3F, 7'h3F, 7'h07, 7'h5B, 7'h06, 7'h3F};
    scan_bc("mid_new", 8);

    wait_done("pre_rst");
    repeat (4) @(negedge clk);
    reset_seq("rst2");
    scan_bc("after_rst", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
